tx_frame: RTL
=============

Name: tx_frame

Overview:
- Serial frame transmitter, directly downstream of the 200 us start-strobe generator.
- On each one-clock start strobe it latches a parallel data word and shifts it out on a single line as a UART-style frame: start bit, DW data bits LSB first, even parity, one stop bit.
- Bit timing comes from an internal clock-cycle counter.
- It provides busy, per-bit and end-of-frame strobes so later stages can chain or count frames.

Parameters:
- Tclk, 20, clock period in ns (50 MHz).
- Tbit, 1000, bit period in ns.
- NB, Tbit/Tclk = 50, clock cycles per bit (must be ≥2).
- DW, 8, data word width (1..16).

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- st  in  1  start strobe, one clk wide (driven by the start-strobe generator).
- dat  in  DW  data word, sampled only in the cycle st is accepted.
- TXD  out  1  serial line, idle high.
- en_tx  out  1  high while a frame is on the line.
- ce_bit  out  1  one-clk pulse in the last cycle of every bit.
- T_end  out  1  one-clk pulse in the last cycle of the stop bit.
- ovr  out  1  one-clk pulse when st arrives while busy and is dropped.

Behaviour:
- Reset (async, rst_n=0): TXD=1, en_tx=0, ce_bit=0, T_end=0, ovr=0, state=IDLE, all counters 0, shift register 0. Reset mid-frame aborts at once: line returns high, no T_end.
- All outputs are registered.
- States: IDLE, START, DATA, PAR, STOP.
- Bit counter cb_tact counts 0..NB-1 within each bit; ce_bit=1 when cb_tact==NB-1.
- IDLE, st=1 at edge k:
  - latch dat into shift reg; compute even parity (XOR of dat).
  - go to START; from k+1 TXD=0 and en_tx=1.
- START: TXD=0 for NB cycles, then DATA.
- DATA:
  - TXD = shift reg bit 0, shift right at each ce_bit.
  - bit index cb_bit counts 0..DW-1.
  - after DW bits go to PAR.
- PAR: TXD = parity bit (XOR of data, so total ones in data+parity is even), NB cycles, then STOP.
- STOP:
  - TXD=1 for NB cycles.
  - T_end=1 in its last cycle, i.e. the cycle starting at edge k+(DW+3)·NB.
  - next state IDLE, en_tx=0 from the following edge.
- Frame timing: bit i (i=0 start … DW+2 stop) occupies cycles k+1+i·NB … k+(i+1)·NB. Total (DW+3)·NB cycles.
- st while en_tx=1 and T_end=0: ignored, frame continues unchanged, ovr=1 for one cycle.
- st in the same cycle as T_end: accepted.
  - new frame's START begins next cycle, no idle gap.
  - en_tx stays high, no ovr.
- st with dat changing after acceptance: no effect on the frame in flight.
- Counter widths:
  - cb_tact is $clog2(NB) bits.
  - cb_bit is $clog2(DW)+1 bits.
  - both clear to 0 on every bit/state wrap.
- ce_bit is high only while en_tx=1.

Test Plan:
- Reset: hold rst_n=0 for 5 cycles with st pulsing → TXD=1, en_tx=en_tx=0, ce_bit=0, T_end=0, ovr=0 throughout.
- Single frame, dat=8'hA5, st at edge k:
  - TXD sequence per 50-cycle bit: 0,1,0,1,0,0,1,0,1, parity 0, stop 1.
  - T_end exactly at cycle k+550.
  - en_tx high k+1..k+550.
  - 11 ce_bit pulses.
- Parity odd-weight, dat=8'h07 → parity bit=1. Also check dat=8'h00 → parity 0 and dat=8'hFF → parity 0.
- Overrun: st at k, second st at k+200 with dat=8'h3C → ovr pulse at k+201, frame still carries first word, single T_end at k+550.
- Back-to-back: second st coincident with T_end (k+550), dat=8'h5A → TXD=0 at k+551, en_tx never drops, second T_end at k+1100.
- Async reset mid-DATA: drop rst_n at k+230 between edges → TXD=1 and en_tx=0 immediately. After release, a new st produces a clean full frame.

Source files
------------

// File: rtl/tx_frame.sv
// UART-style frame transmitter: start bit, DW data bits LSB first, even parity, stop bit.
// Each bit lasts NB clocks; busy, per-bit, end-of-frame and overrun strobes are registered.
module tx_frame #(
    parameter int Tclk = 20,
    parameter int Tbit = 1000,
    parameter int NB   = Tbit / Tclk,
    parameter int DW   = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          st,
    input  logic [DW-1:0] dat,
    output logic          TXD,
    output logic          en_tx,
    output logic          ce_bit,
    output logic          T_end,
    output logic          ovr
);

    localparam int TW = (NB > 1) ? $clog2(NB) : 1;
    localparam int BW = $clog2(DW) + 1;
    localparam logic [TW-1:0] TACT_LAST = TW'(NB - 1);
    localparam logic [TW-1:0] TACT_PRE  = TW'(NB - 2);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DW - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t        r_state;
    logic [TW-1:0] r_cb_tact;
    logic [BW-1:0] r_cb_bit;
    logic [DW-1:0] r_shreg;
    logic          r_par;
    logic          r_txd;
    logic          r_en_tx;
    logic          r_ce_bit;
    logic          r_t_end;
    logic          r_ovr;

    logic w_busy;
    logic w_tact_wrap;
    logic w_last;
    logic w_accept;
    logic w_next_bit;

    assign w_busy      = (r_state != IDLE);
    assign w_tact_wrap = (r_cb_tact == TACT_LAST);
    // Last cycle of the stop bit: a start here chains the next frame with no idle gap.
    assign w_last      = (r_state == STOP) && w_tact_wrap;
    assign w_accept    = st && (!w_busy || w_last);

    generate
        if (DW > 1) begin : g_next_wide
            assign w_next_bit = r_shreg[1];
        end else begin : g_next_single
            assign w_next_bit = 1'b0;
        end
    endgenerate

    // Strobes are produced one cycle early from cb_tact==NB-2 so they line up with cb_tact==NB-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cb_tact <= '0;
            r_cb_bit  <= '0;
            r_shreg   <= '0;
            r_par     <= 1'b0;
            r_txd     <= 1'b1;
            r_en_tx   <= 1'b0;
            r_ce_bit  <= 1'b0;
            r_t_end   <= 1'b0;
            r_ovr     <= 1'b0;
        end else begin
            r_ovr <= st && w_busy && !w_last;
            if (w_accept) begin
                r_state   <= START;
                r_cb_tact <= '0;
                r_cb_bit  <= '0;
                r_shreg   <= dat;
                r_par     <= ^dat;
                r_txd     <= 1'b0;
                r_en_tx   <= 1'b1;
                r_ce_bit  <= 1'b0;
                r_t_end   <= 1'b0;
            end else if (w_busy) begin
                if (w_tact_wrap) begin
                    r_cb_tact <= '0;
                    r_ce_bit  <= 1'b0;
                    r_t_end   <= 1'b0;
                    case (r_state)
                        START: begin
                            r_state  <= DATA;
                            r_cb_bit <= '0;
                            r_txd    <= r_shreg[0];
                        end
                        DATA: begin
                            r_shreg <= r_shreg >> 1;
                            if (r_cb_bit == BIT_LAST) begin
                                r_state  <= PAR;
                                r_cb_bit <= '0;
                                r_txd    <= r_par;
                            end else begin
                                r_cb_bit <= r_cb_bit + 1'b1;
                                r_txd    <= w_next_bit;
                            end
                        end
                        PAR: begin
                            r_state <= STOP;
                            r_txd   <= 1'b1;
                        end
                        default: begin
                            r_state <= IDLE;
                            r_txd   <= 1'b1;
                            r_en_tx <= 1'b0;
                        end
                    endcase
                end else begin
                    r_cb_tact <= r_cb_tact + 1'b1;
                    r_ce_bit  <= (r_cb_tact == TACT_PRE);
                    r_t_end   <= (r_state == STOP) && (r_cb_tact == TACT_PRE);
                end
            end
        end
    end

    assign TXD    = r_txd;
    assign en_tx  = r_en_tx;
    assign ce_bit = r_ce_bit;
    assign T_end  = r_t_end;
    assign ovr    = r_ovr;

endmodule
